// File: rtl/seq_engine_arbiter.sv
// rtl/seq_engine_arbiter.sv - round-robin arbiter/sequencer sharing one three-step sequence engine
//
// Purpose:
//   Grants one of NREQ requesters at a time, fires the shared engine with a
//   one-cycle trigger word of 1, then checks that the engine answers 1 and
//   then 2. Each transaction reports its status, can set a sticky error and
//   advances a wrapping transaction counter.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   i_enable      permits new grants (an in-flight transaction always completes)
//   i_req         per-requester request levels, sampled only in IDLE
//   i_err_clr     synchronous clear of o_err_sticky (a same-cycle failure wins)
//   i_eng_out     engine output_signal
//   o_gnt         one-hot grant, held for the whole transaction
//   o_busy        high whenever the sequencer is not idle
//   o_done        one-cycle end-of-transaction pulse
//   o_status_ok   valid with o_done: engine answered 1 then 2
//   o_err_sticky  set by any failed transaction
//   o_txn_count   number of completed transactions, wraps
//   o_eng_in      engine input_signal (registered)

module seq_engine_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic [NREQ-1:0]  i_req,
    input  logic             i_err_clr,
    input  logic [WIDTH-1:0] i_eng_out,
    output logic [NREQ-1:0]  o_gnt,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_status_ok,
    output logic             o_err_sticky,
    output logic [CNT_W-1:0] o_txn_count,
    output logic [WIDTH-1:0] o_eng_in
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_SEE_A   = 3'd2,
        S_SEE_B   = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [NREQ-1:0]    r_gnt;
    logic [IDX_W-1:0]   r_last_gnt;
    logic               r_ok_a;
    logic               r_ok_b;
    logic               r_err_sticky;
    logic [CNT_W-1:0]   r_txn_count;
    logic [WIDTH-1:0]   r_eng_in;

    logic               w_found;
    logic [IDX_W-1:0]   w_win_idx;
    logic [NREQ-1:0]    w_win_onehot;
    logic [IDX_W:0]     w_sum;
    logic [IDX_W-1:0]   w_cand;
    logic               w_txn_fail;

    // Round-robin search starting just after the last winner. The extra bit
    // in w_sum lets the wrap be a single conditional subtract, which keeps
    // non-power-of-two NREQ correct.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_sum     = '0;
        w_cand    = '0;
        for (int off = 1; off <= NREQ; off++) begin
            w_sum = {1'b0, r_last_gnt} + (IDX_W+1)'(off);
            if (w_sum >= (IDX_W+1)'(NREQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NREQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!w_found && i_req[w_cand]) begin
                w_found   = 1'b1;
                w_win_idx = w_cand;
            end
        end
    end

    assign w_win_onehot = NREQ'(1) << w_win_idx;
    assign w_txn_fail   = !(r_ok_a && r_ok_b);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_nxt = S_IDLE;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        o_status_ok = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy      = 1'b0;
                w_state_nxt = (i_enable && w_found) ? S_ISSUE : S_IDLE;
            end
            S_ISSUE:   w_state_nxt = S_SEE_A;
            S_SEE_A:   w_state_nxt = S_SEE_B;
            S_SEE_B:   w_state_nxt = S_RELEASE;
            S_RELEASE: begin
                o_done      = 1'b1;
                o_status_ok = !w_txn_fail;
                w_state_nxt = S_IDLE;
            end
            default: begin
                o_busy      = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: grant, trigger word, response capture, counter, sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt        <= '0;
            r_last_gnt   <= IDX_W'(NREQ - 1);
            r_ok_a       <= 1'b0;
            r_ok_b       <= 1'b0;
            r_err_sticky <= 1'b0;
            r_txn_count  <= '0;
            r_eng_in     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_enable && w_found) begin
                        r_gnt      <= w_win_onehot;
                        r_last_gnt <= w_win_idx;
                        r_eng_in   <= WIDTH'(1);
                    end
                end
                S_ISSUE: begin
                    r_eng_in <= '0;
                end
                S_SEE_A: begin
                    r_ok_a <= (i_eng_out == WIDTH'(1));
                end
                S_SEE_B: begin
                    r_ok_b <= (i_eng_out == WIDTH'(2));
                end
                S_RELEASE: begin
                    r_gnt       <= '0;
                    r_txn_count <= r_txn_count + CNT_W'(1);
                end
                default: begin
                    r_gnt    <= '0;
                    r_eng_in <= '0;
                end
            endcase

            // A failure being recorded takes priority over a clear request.
            if (r_state == S_RELEASE && w_txn_fail) begin
                r_err_sticky <= 1'b1;
            end else if (i_err_clr) begin
                r_err_sticky <= 1'b0;
            end
        end
    end

    assign o_gnt        = r_gnt;
    assign o_err_sticky = r_err_sticky;
    assign o_txn_count  = r_txn_count;
    assign o_eng_in     = r_eng_in;

endmodule

// File: tb/tb_seq_engine_arbiter.sv
// tb/tb_seq_engine_arbiter.sv - directed self-checking bench for seq_engine_arbiter

module tb_seq_engine_arbiter;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [3:0] req;
    logic       err_clr;
    logic [7:0] eng_out;
    logic [3:0] gnt;
    logic       busy;
    logic       done;
    logic       status_ok;
    logic       err_sticky;
    logic [3:0] txn_count;
    logic [7:0] eng_in;
    logic       bad;

    int checks   = 0;
    int failures = 0;

    seq_engine_arbiter #(.WIDTH(8), .NREQ(4), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_enable     (enable),
        .i_req        (req),
        .i_err_clr    (err_clr),
        .i_eng_out    (eng_out),
        .o_gnt        (gnt),
        .o_busy       (busy),
        .o_done       (done),
        .o_status_ok  (status_ok),
        .o_err_sticky (err_sticky),
        .o_txn_count  (txn_count),
        .o_eng_in     (eng_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: trigger 1 -> answers 1, then 2 (or 3 when bad), then 0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_out <= 8'd0;
        end else if (eng_in == 8'd1) begin
            eng_out <= 8'd1;
        end else if (eng_out == 8'd1) begin
            eng_out <= bad ? 8'd3 : 8'd2;
        end else begin
            eng_out <= 8'd0;
        end
    end

    task automatic do_reset;
        @(negedge clk);
        rst_n   = 1'b0;
        req     = 4'b0000;
        enable  = 1'b1;
        err_clr = 1'b0;
        bad     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        req     = 4'b0000;
        enable  = 1'b1;
        err_clr = 1'b0;
        bad     = 1'b0;
        #12;
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: gnt=%b busy=%b done=%b required 0000 0 0", gnt, busy, done);
        end
        checks++;
        if (status_ok !== 1'b0 || err_sticky !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: status_ok=%b err=%b required 0 0", status_ok, err_sticky);
        end
        checks++;
        if (txn_count !== 4'd0 || eng_in !== 8'd0) begin
            failures++;
            $display("FAIL reset_data: count=%0d eng_in=%0d required 0 0", txn_count, eng_in);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        checks++;
        if (gnt !== 4'b0001 || eng_in !== 8'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_c1: gnt=%b eng_in=%0d busy=%b required 0001 1 1", gnt, eng_in, busy);
        end
        @(negedge clk);
        checks++;
        if (eng_in !== 8'd0) begin
            failures++;
            $display("FAIL single_c2_eng_in: got %0d required 0", eng_in);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || status_ok !== 1'b1) begin
            failures++;
            $display("FAIL single_c4: done=%b status_ok=%b required 1 1", done, status_ok);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || txn_count !== 4'd1) begin
            failures++;
            $display("FAIL single_c5: gnt=%b busy=%b done=%b count=%0d required 0000 0 0 1",
                     gnt, busy, done, txn_count);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] prev_gnt;
        logic [3:0] exp_gnt;
        int n;
        int cyc;
        int last_cyc;
        do_reset();
        req      = 4'b1111;
        prev_gnt = 4'b0000;
        n        = 0;
        cyc      = 0;
        last_cyc = 0;
        for (int c = 0; c < 200 && n < 20; c++) begin
            @(negedge clk);
            cyc++;
            if (gnt !== 4'b0000 && prev_gnt === 4'b0000) begin
                exp_gnt = 4'b0001 << (n % 4);
                checks++;
                if (gnt !== exp_gnt) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: got %b required %b", n, gnt, exp_gnt);
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - last_cyc != 5) begin
                        failures++;
                        $display("FAIL rr_spacing[%0d]: got %0d cycles required 5", n, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                n++;
                if (n == 20) req = 4'b0000;
            end
            prev_gnt = gnt;
        end
        checks++;
        if (n != 20) begin
            failures++;
            $display("FAIL rr_timeout: got %0d grants required 20", n);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || txn_count !== 4'd4) begin
            failures++;
            $display("FAIL rr_end: busy=%b count=%0d required 0 4", busy, txn_count);
        end
    endtask

    task automatic test_error;
        do_reset();
        bad = 1'b1;
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b1 || status_ok !== 1'b0 || err_sticky !== 1'b0) begin
            failures++;
            $display("FAIL err_c4: done=%b status_ok=%b err=%b required 1 0 0", done, status_ok, err_sticky);
        end
        @(negedge clk);
        checks++;
        if (err_sticky !== 1'b1 || status_ok !== 1'b0) begin
            failures++;
            $display("FAIL err_set: err=%b status_ok=%b required 1 0", err_sticky, status_ok);
        end
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        err_clr = 1'b1;
        checks++;
        if (done !== 1'b1 || status_ok !== 1'b0) begin
            failures++;
            $display("FAIL err2_c4: done=%b status_ok=%b required 1 0", done, status_ok);
        end
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (err_sticky !== 1'b1) begin
            failures++;
            $display("FAIL err_set_wins: got %b required 1", err_sticky);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (err_sticky !== 1'b0 || txn_count !== 4'd2) begin
            failures++;
            $display("FAIL err_clear: err=%b count=%0d required 0 2", err_sticky, txn_count);
        end
        bad = 1'b0;
    endtask

    task automatic test_enable;
        int bad_cycles;
        do_reset();
        enable     = 1'b0;
        req        = 4'b0011;
        bad_cycles = 0;
        repeat (10) begin
            @(negedge clk);
            if (gnt !== 4'b0000 || busy !== 1'b0) bad_cycles++;
        end
        checks++;
        if (bad_cycles != 0) begin
            failures++;
            $display("FAIL en_off_idle: got %0d active cycles required 0", bad_cycles);
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL en_grant: got %b required 0001", gnt);
        end
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1 || status_ok !== 1'b1) begin
            failures++;
            $display("FAIL en_drop_done: done=%b status_ok=%b required 1 1", done, status_ok);
        end
        bad_cycles = 0;
        repeat (9) begin
            @(negedge clk);
            if (gnt !== 4'b0000 || busy !== 1'b0) bad_cycles++;
        end
        checks++;
        if (bad_cycles != 0) begin
            failures++;
            $display("FAIL en_no_regrant: got %0d active cycles required 0", bad_cycles);
        end
        enable = 1'b1;
        @(negedge clk);
        req = 4'b0000;
        checks++;
        if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL en_resume: got %b required 0010", gnt);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (txn_count !== 4'd2) begin
            failures++;
            $display("FAIL en_count: got %0d required 2", txn_count);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        repeat (4) @(negedge clk);
        checks++;
        if (txn_count !== 4'd1) begin
            failures++;
            $display("FAIL rmid_pre_count: got %0d required 1", txn_count);
        end
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || eng_in !== 8'd0) begin
            failures++;
            $display("FAIL rmid_async: gnt=%b busy=%b done=%b eng_in=%0d required 0000 0 0 0",
                     gnt, busy, done, eng_in);
        end
        checks++;
        if (txn_count !== 4'd0 || status_ok !== 1'b0 || err_sticky !== 1'b0) begin
            failures++;
            $display("FAIL rmid_state: count=%0d status_ok=%b err=%b required 0 0 0",
                     txn_count, status_ok, err_sticky);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || txn_count !== 4'd0) begin
            failures++;
            $display("FAIL rmid_held: done=%b count=%0d required 0 0", done, txn_count);
        end
        rst_n = 1'b1;
        req   = 4'b1000;
        @(negedge clk);
        req = 4'b0000;
        checks++;
        if (gnt !== 4'b1000) begin
            failures++;
            $display("FAIL rmid_gnt3: got %b required 1000", gnt);
        end
        repeat (4) @(negedge clk);
        do_reset();
        req = 4'b1001;
        @(negedge clk);
        req = 4'b0000;
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL rmid_first_wins: got %b required 0001", gnt);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_wrap;
        int waited;
        do_reset();
        req = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            waited = 0;
            while (done !== 1'b1 && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            checks++;
            if (done !== 1'b1 || status_ok !== 1'b1) begin
                failures++;
                $display("FAIL wrap_done[%0d]: done=%b status_ok=%b required 1 1", k, done, status_ok);
            end
            @(negedge clk);
            if (k == 15) req = 4'b0000;
            checks++;
            if (txn_count !== 4'((k + 1) % 16)) begin
                failures++;
                $display("FAIL wrap_count[%0d]: got %0d required %0d", k, txn_count, (k + 1) % 16);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || txn_count !== 4'd0 || err_sticky !== 1'b0) begin
            failures++;
            $display("FAIL wrap_end: busy=%b count=%0d err=%b required 0 0 0", busy, txn_count, err_sticky);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_error();
        test_enable();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
